// File: rtl/sram_column_fetch_if.sv
// rtl/sram_column_fetch_if.sv - fetch request, SRAM read port and column output bundle
interface sram_column_fetch_if #(
    parameter int WIN_H = 5,
    parameter int PIX_W = 8
);
    logic                     start;
    logic [31:0]              anchor_x;
    logic [31:0]              anchor_y;
    logic [31:0]              width;
    logic [31:0]              height;
    logic [31:0]              base_addr;
    logic [31:0]              sram_addr;
    logic                     sram_read_enable;
    logic [PIX_W-1:0]         sram_rdata;
    logic                     io_final;
    logic                     col_valid;
    logic [WIN_H*PIX_W-1:0]   col_data;
    logic                     busy;

    modport slave (
        input  start, anchor_x, anchor_y, width, height, base_addr, sram_rdata,
        output sram_addr, sram_read_enable, io_final, col_valid, col_data, busy
    );

    modport master (
        output start, anchor_x, anchor_y, width, height, base_addr, sram_rdata,
        input  sram_addr, sram_read_enable, io_final, col_valid, col_data, busy
    );
endinterface

// File: rtl/sram_column_fetch.sv
// rtl/sram_column_fetch.sv - reads one WIN_H-pixel column from SRAM with zero padding
module sram_column_fetch #(
    parameter int WIN_H = 5,
    parameter int PIX_W = 8
) (
    input  logic               clk,
    input  logic               n_rst,
    sram_column_fetch_if.slave bus
);
    localparam int RW = $clog2(WIN_H);

    typedef enum logic [1:0] {IDLE, ISSUE, LAST} state_t;

    state_t                 state;
    logic [31:0]            x_q, y_q, w_q, h_q, b_q;
    logic [RW-1:0]          cur_row, nxt_row, cap_row;
    logic                   cur_oob, cap_oob, cap_en;
    logic [WIN_H*PIX_W-1:0] shadow, shadow_next, col_q;
    logic [31:0]            addr_q;
    logic                   re_q, final_q, valid_q, busy_q;
    logic [32:0]            req;

    // {out_of_bounds, address}; row index wraps in 32 bits before the bounds test
    function automatic logic [32:0] row_req(input logic [31:0] b, x, y, w, h, r);
        logic [31:0] yr;
        yr = y + r;
        if ((x < w) && (yr < h))
            return {1'b0, b + yr * w + x};
        else
            return {1'b1, 32'd0};
    endfunction

    always_comb begin
        nxt_row = (state == IDLE) ? '0 : cur_row + 1'b1;
        if (state == IDLE)
            req = row_req(bus.base_addr, bus.anchor_x, bus.anchor_y,
                          bus.width, bus.height, 32'(nxt_row));
        else
            req = row_req(b_q, x_q, y_q, w_q, h_q, 32'(nxt_row));
        shadow_next = shadow;
        if (cap_en)
            shadow_next[int'(cap_row)*PIX_W +: PIX_W] = cap_oob ? '0 : bus.sram_rdata;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            b_q     <= '0;
            cur_row <= '0;
            cur_oob <= 1'b0;
            cap_row <= '0;
            cap_oob <= 1'b0;
            cap_en  <= 1'b0;
            shadow  <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            re_q    <= 1'b0;
            final_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // read data lags the strobe by one cycle, so the issued row is tracked one stage behind
            cap_en  <= (state == ISSUE);
            cap_row <= cur_row;
            cap_oob <= cur_oob;
            shadow  <= shadow_next;
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        x_q     <= bus.anchor_x;
                        y_q     <= bus.anchor_y;
                        w_q     <= bus.width;
                        h_q     <= bus.height;
                        b_q     <= bus.base_addr;
                        cur_row <= nxt_row;
                        cur_oob <= req[32];
                        re_q    <= ~req[32];
                        addr_q  <= req[31:0];
                        busy_q  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cur_row == RW'(WIN_H - 1)) begin
                        re_q    <= 1'b0;
                        addr_q  <= '0;
                        final_q <= 1'b1;
                        state   <= LAST;
                    end else begin
                        cur_row <= nxt_row;
                        cur_oob <= req[32];
                        re_q    <= ~req[32];
                        addr_q  <= req[31:0];
                    end
                end
                LAST: begin
                    final_q <= 1'b0;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                    col_q   <= shadow_next;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sram_addr        = addr_q;
    assign bus.sram_read_enable = re_q;
    assign bus.io_final         = final_q;
    assign bus.col_valid        = valid_q;
    assign bus.col_data         = col_q;
    assign bus.busy             = busy_q;
endmodule

// File: tb/tb_sram_column_fetch.sv
// tb/tb_sram_column_fetch.sv - directed self-checking bench for sram_column_fetch
module tb_sram_column_fetch;
    logic clk;
    logic n_rst;

    sram_column_fetch_if #(.WIN_H(5), .PIX_W(8)) bus ();

    sram_column_fetch #(.WIN_H(5), .PIX_W(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: data = low address byte, one cycle after the strobe; junk when not read
    always @(posedge clk)
        bus.sram_rdata <= bus.sram_read_enable ? bus.sram_addr[7:0] : 8'hA5;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] re_mask, fin_mask, val_mask;
    logic [39:0] last_col;
    logic [31:0] addr_q[$];

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] x, y, w, h, b, input bit hold, input int ncyc);
        @(negedge clk);
        bus.anchor_x  = x;
        bus.anchor_y  = y;
        bus.width     = w;
        bus.height    = h;
        bus.base_addr = b;
        bus.start     = 1'b1;
        re_mask  = '0;
        fin_mask = '0;
        val_mask = '0;
        addr_q.delete();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            if (bus.sram_read_enable) begin
                re_mask[c] = 1'b1;
                addr_q.push_back(bus.sram_addr);
            end
            if (bus.io_final)  fin_mask[c] = 1'b1;
            if (bus.col_valid) begin
                val_mask[c] = 1'b1;
                last_col    = bus.col_data;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_value({pfx, "_addr"},  {32'd0, bus.sram_addr}, 64'd0);
        check_value({pfx, "_re"},    {63'd0, bus.sram_read_enable}, 64'd0);
        check_value({pfx, "_final"}, {63'd0, bus.io_final}, 64'd0);
        check_value({pfx, "_valid"}, {63'd0, bus.col_valid}, 64'd0);
        check_value({pfx, "_col"},   {24'd0, bus.col_data}, 64'd0);
        check_value({pfx, "_busy"},  {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        n_rst = 1'b0;
        bus.start = 1'b0;
        bus.anchor_x = '0;
        bus.anchor_y = '0;
        bus.width = '0;
        bus.height = '0;
        bus.base_addr = '0;
        last_col = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        n_rst = 1'b1;
        @(negedge clk);

        // basic interior column
        do_fetch(32'd3, 32'd2, 32'd10, 32'd10, 32'h100, 1'b0, 9);
        check_value("t1_re_mask",  {32'd0, re_mask},  64'h3E);
        check_value("t1_n_addr",   64'(addr_q.size()), 64'd5);
        check_value("t1_addr0",    {32'd0, addr_q[0]}, 64'h117);
        check_value("t1_addr1",    {32'd0, addr_q[1]}, 64'h121);
        check_value("t1_addr2",    {32'd0, addr_q[2]}, 64'h12B);
        check_value("t1_addr3",    {32'd0, addr_q[3]}, 64'h135);
        check_value("t1_addr4",    {32'd0, addr_q[4]}, 64'h13F);
        check_value("t1_fin_mask", {32'd0, fin_mask}, 64'h40);
        check_value("t1_val_mask", {32'd0, val_mask}, 64'h80);
        check_value("t1_col",      {24'd0, last_col}, 64'h3F352B2117);
        check_value("t1_col_hold", {24'd0, bus.col_data}, 64'h3F352B2117);

        // bottom edge: last two rows padded
        do_fetch(32'd0, 32'd7, 32'd10, 32'd10, 32'd0, 1'b0, 9);
        check_value("t2_re_mask",  {32'd0, re_mask},  64'h0E);
        check_value("t2_addr0",    {32'd0, addr_q[0]}, 64'd70);
        check_value("t2_addr1",    {32'd0, addr_q[1]}, 64'd80);
        check_value("t2_addr2",    {32'd0, addr_q[2]}, 64'd90);
        check_value("t2_fin_mask", {32'd0, fin_mask}, 64'h40);
        check_value("t2_val_mask", {32'd0, val_mask}, 64'h80);
        check_value("t2_col",      {24'd0, last_col}, 64'h00005A5046);

        // padding column to the right of the image
        do_fetch(32'd12, 32'd0, 32'd10, 32'd10, 32'd0, 1'b0, 9);
        check_value("t3_re_mask",  {32'd0, re_mask},  64'h0);
        check_value("t3_fin_mask", {32'd0, fin_mask}, 64'h40);
        check_value("t3_val_mask", {32'd0, val_mask}, 64'h80);
        check_value("t3_col",      {24'd0, last_col}, 64'h0);

        // row index wraps past 2^32 and lands back inside the image
        do_fetch(32'd0, 32'hFFFF_FFFE, 32'd10, 32'd10, 32'h40, 1'b0, 9);
        check_value("t4_re_mask",  {32'd0, re_mask},  64'h38);
        check_value("t4_addr0",    {32'd0, addr_q[0]}, 64'h40);
        check_value("t4_addr2",    {32'd0, addr_q[2]}, 64'h54);
        check_value("t4_col",      {24'd0, last_col}, 64'h544A400000);

        // start held high: back-to-back fetches, busy-time starts ignored
        do_fetch(32'd0, 32'd0, 32'd10, 32'd10, 32'd0, 1'b1, 21);
        check_value("t5_val_mask", {32'd0, val_mask}, 64'h0020_4080);
        check_value("t5_fin_mask", {32'd0, fin_mask}, 64'h0010_2040);
        check_value("t5_n_reads",  64'(addr_q.size()), 64'd15);
        check_value("t5_col",      {24'd0, last_col}, 64'h281E140A00);
        repeat (10) @(negedge clk);

        // asynchronous reset in the middle of a fetch
        @(negedge clk);
        bus.anchor_x = 32'd3;
        bus.anchor_y = 32'd2;
        bus.width = 32'd10;
        bus.height = 32'd10;
        bus.base_addr = 32'h100;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_value("t6_busy_pre", {63'd0, bus.busy}, 64'd1);
        n_rst = 1'b0;
        #1;
        check_outputs_zero("t6_rst");
        @(negedge clk);
        n_rst = 1'b1;
        fin_mask = '0;
        val_mask = '0;
        re_mask  = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.io_final)         fin_mask[c] = 1'b1;
            if (bus.col_valid)        val_mask[c] = 1'b1;
            if (bus.sram_read_enable) re_mask[c]  = 1'b1;
        end
        check_value("t6_fin_mask", {32'd0, fin_mask}, 64'h0);
        check_value("t6_val_mask", {32'd0, val_mask}, 64'h0);
        check_value("t6_re_mask",  {32'd0, re_mask},  64'h0);
        check_value("t6_col",      {24'd0, bus.col_data}, 64'h0);

        // empty image
        do_fetch(32'd0, 32'd0, 32'd0, 32'd0, 32'h200, 1'b0, 9);
        check_value("t7_re_mask",  {32'd0, re_mask},  64'h0);
        check_value("t7_fin_mask", {32'd0, fin_mask}, 64'h40);
        check_value("t7_val_mask", {32'd0, val_mask}, 64'h80);
        check_value("t7_col",      {24'd0, last_col}, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_column_fetch.md
Name: sram_column_fetch

Overview:
- Upstream I/O stage of the filter pipeline: on each anchor step, reads one vertical column of WIN_H pixels from SRAM and hands it to the blur window as a packed word.
- Column is at anchor_x, rows anchor_y .. anchor_y+WIN_H-1.
- Pixels outside the image are zero-padded without touching SRAM.
- Drives io_final, the "I/O complete next cycle" input of the main filter controller.

Parameters:
- WIN_H, 5, pixels per column (rows of the filter window), >= 2.
- PIX_W, 8, bits per pixel.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- start  input  1  begin a column fetch; sampled only in IDLE.
- anchor_x  input  32  column index of the fetch.
- anchor_y  input  32  top row index of the fetch.
- width  input  32  image width in pixels.
- height  input  32  image height in pixels.
- base_addr  input  32  SRAM byte address of pixel (0,0).
- sram_addr  output  32  SRAM read address.
- sram_read_enable  output  1  SRAM read strobe; data returns exactly 1 cycle later.
- sram_rdata  input  PIX_W  SRAM read data.
- io_final  output  1  fetch completes next cycle.
- col_valid  output  1  one-cycle pulse: col_data holds a new column.
- col_data  output  WIN_H*PIX_W  row r at bits [r*PIX_W +: PIX_W].
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset, asynchronous, any state: state=IDLE.
  - All outputs 0: sram_addr, sram_read_enable, io_final, col_valid, col_data, busy.
  - A fetch in flight is abandoned; nothing is emitted after reset releases.
- States: IDLE, ISSUE, LAST.
- IDLE:
  - If start=1, latch anchor_x, anchor_y, width, height and base_addr; set row counter r=0; go to ISSUE.
  - Otherwise stay in IDLE.
  - Inputs are not re-sampled until the next IDLE.
- ISSUE, one row per cycle, for r = 0..WIN_H-1:
  - In bounds means x < width and (y+r) < height, compared unsigned.
  - In bounds: sram_read_enable=1 and sram_addr = base + (y+r)*width + x, taken mod 2^32.
  - Out of bounds: sram_read_enable=0, sram_addr=0, and a zero flag is queued for that row.
  - After issuing row WIN_H-1, go to LAST.
- Capture:
  - Each cycle after an issue, that row's slot in a shadow register takes sram_rdata, or 0 if the row was flagged out of bounds.
  - col_data does not change during the fetch.
- LAST:
  - io_final=1 for exactly this cycle; the final row is captured.
  - On the clock edge leaving LAST: col_data <= shadow, col_valid <= 1, state <= IDLE.
- Latency: start seen at cycle 0.
  - Reads issue in cycles 1..WIN_H.
  - io_final in cycle WIN_H+1.
  - col_valid in cycle WIN_H+2.
  - Total WIN_H+2 cycles start-to-valid; 7 for the default.
- col_valid and col_data:
  - col_valid is a registered single-cycle pulse.
  - col_data holds its value until the next col_valid.
- start handling:
  - start while busy=1 is ignored, not queued.
  - start in the same cycle as col_valid is accepted, since the state is IDLE; back-to-back throughput is 1 column per WIN_H+2 cycles.
- Degenerate images:
  - width=0 or height=0: every row is out of bounds; the fetch still takes full latency and emits all-zero col_data.
  - anchor_x >= width (right-edge padding columns): all-zero column with full latency.
- Width rules:
  - (y+r) is computed in 32 bits; overflow wraps and the bounds compare uses the wrapped value.
  - The product is truncated to 32 bits.
- sram_read_enable is never high outside ISSUE.

Test Plan:
- Reset, then pulse start with base=0x100, width=10, height=10, x=3, y=2, SRAM[a]=a[7:0]:
  - addresses 0x117, 0x121, 0x12B, 0x135, 0x13F in cycles 1-5;
  - io_final in cycle 6;
  - col_valid in cycle 7 with rows = 0x17, 0x21, 0x2B, 0x35, 0x3F.
- Bottom edge, height=10, y=7, x=0, base=0:
  - reads only at 70, 80, 90;
  - rows 3-4 are zero with no strobe;
  - latency is still 7.
- Padding column, x=12, width=10:
  - no sram_read_enable at all;
  - io_final in cycle 6, col_valid in cycle 7, col_data=0.
- start held high continuously with y=0, width=height=10:
  - col_valid at cycles 7, 14, 21;
  - start pulses during busy produce no extra fetches.
- Assert n_rst low in cycle 3 of a fetch:
  - all outputs 0 immediately;
  - after release with start=0, no io_final or col_valid ever appears;
  - previous col_data is cleared to 0.
- width=0, height=0, start:
  - all-zero column with col_valid in cycle 7;
  - no SRAM access.
